cla_seq_ctrl: RTL and testbench



---
 rtl/cla_seq_ctrl.sv | 88 ++++++++
 tb/tb_cla_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: nibble-serial WIDTH-bit adder sequencer driving one external cla4 slice.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + op_a/op_b/op_ci operand handshake;
// out_valid/out_ready + sum/cout result handshake; slice_a/slice_b/slice_ci to the cla4 slice,
// slice_s/slice_co back from it.
// Optional: define CLA_SEQ_SUB_EN to add op_sub (A-B via ~B and carry-in 1; cout=1 means no borrow).
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_ci,
`ifdef CLA_SEQ_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_ci,
  input  logic [3:0]       slice_s,
  input  logic             slice_co
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW+1:0] bit_idx;
  logic carry, cout_reg, last, run;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, b_in;
  logic c_in;
`ifdef CLA_SEQ_SUB_EN
  assign b_in = op_sub ? ~op_b : op_b;
  assign c_in = op_sub ? 1'b1 : op_ci;
`else
  assign b_in = op_b;
  assign c_in = op_ci;
`endif
  assign bit_idx = {cnt, 2'b00};
  assign last = cnt == CW'(NIB - 1);
  assign run = state == RUN;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign sum = sum_reg;
  assign cout = cout_reg;
  assign slice_a = run ? a_reg[bit_idx +: 4] : 4'h0;
  assign slice_b = run ? b_reg[bit_idx +: 4] : 4'h0;
  assign slice_ci = run ? carry : 1'b0;
  // slice_s/slice_co are only sampled in RUN so an idle slice cannot leak X into state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      cout_reg <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum_reg <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= op_a;
          b_reg <= b_in;
          carry <= c_in;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          sum_reg[bit_idx +: 4] <= slice_s;
          carry <= slice_co;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            cout_reg <= slice_co;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: directed and randomized checks of cla_seq_ctrl against an arithmetic model.
module tb_cla_seq_ctrl;
  localparam int W = 16;
  localparam int N = W / 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic op_ci = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic in_ready, out_valid, cout, slice_ci, slice_co;
  logic [W-1:0] sum;
  logic [3:0] slice_a, slice_b, slice_s;
`ifdef CLA_SEQ_SUB_EN
  logic op_sub = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  assign {slice_co, slice_s} = 5'(slice_a) + 5'(slice_b) + 5'(slice_ci);

  cla_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_ci(op_ci),
`ifdef CLA_SEQ_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .slice_a(slice_a), .slice_b(slice_b), .slice_ci(slice_ci),
    .slice_s(slice_s), .slice_co(slice_co)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_slice(input string tag);
    check({tag, "_slice_a"}, slice_a, 0);
    check({tag, "_slice_b"}, slice_b, 0);
    check({tag, "_slice_ci"}, slice_ci, 0);
  endtask

  // One full transaction: accept, watch each nibble, hold the result for `hold` cycles, release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub, input int hold);
    logic [W-1:0] bb;
    logic c0;
    logic [W:0] full;
    longint unsigned lo;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(c0);
    check("idle_in_ready", in_ready, 1);
    op_a = a;
    op_b = b;
    op_ci = ci;
`ifdef CLA_SEQ_SUB_EN
    op_sub = sub;
`endif
    out_ready = 1'b0;
    in_valid = 1'b1;
    step;
    in_valid = 1'b1;
    op_a = W'($urandom);
    op_b = W'($urandom);
    for (int k = 0; k < N; k++) begin
      lo = (longint'(a) % (64'd1 << (4 * k))) + (longint'(bb) % (64'd1 << (4 * k))) + c0;
      check("run_slice_ci", slice_ci, 32'(lo >> (4 * k)));
      check("run_slice_a", slice_a, (a >> (4 * k)) & 16'hf);
      check("run_slice_b", slice_b, (bb >> (4 * k)) & 16'hf);
      check("run_in_ready", in_ready, 0);
      check("run_out_valid", out_valid, 0);
      step;
    end
    in_valid = 1'b0;
    check("done_out_valid", out_valid, 1);
    check("done_sum", sum, full[W-1:0]);
    check("done_cout", cout, full[W]);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op_a = W'($urandom);
      op_b = W'($urandom);
      step;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, full[W-1:0]);
      check("hold_cout", cout, full[W]);
      check_idle_slice("hold");
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("release_sum_kept", sum, full[W-1:0]);
    check("release_cout_kept", cout, full[W]);
  endtask

  initial begin
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];
    logic [W:0] expq[$];
    int acc_t[$];
    int got;
    int idx;
    logic acc;
    step;
    step;
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check_idle_slice("rst");

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h8001, 16'h7FFF, 1'b1, 1'b0, 5);

    op_a = 16'h00F0;
    op_b = 16'h0010;
    op_ci = 1'b0;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check_idle_slice("abort");
    step;
    check("abort_no_valid", out_valid, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    reset = 1'b1;
    in_valid = 1'b1;
    op_a = 16'h1111;
    op_b = 16'h2222;
    step;
    reset = 1'b0;
    in_valid = 1'b0;
    check("rstvalid_in_ready", in_ready, 1);
    check_idle_slice("rstvalid");
    step;
    check("rstvalid_still_idle", in_ready, 1);
    check("rstvalid_out_valid", out_valid, 0);

    pa[0] = 16'h0102; pb[0] = 16'h0304;
    pa[1] = 16'hF00F; pb[1] = 16'h1FF1;
    pa[2] = 16'hABCD; pb[2] = 16'h5432;
    idx = 0;
    got = 0;
    op_a = pa[0];
    op_b = pb[0];
    op_ci = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (out_valid) begin
        if (expq.size() == 0) check("b2b_unexpected_result", 1, 0);
        else check("b2b_result", {cout, sum}, expq.pop_front());
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) expq.push_back({1'b0, op_a} + {1'b0, op_b} + 17'(op_ci));
      step;
      if (acc) begin
        acc_t.push_back(cyc);
        idx++;
        if (idx < 3) begin
          op_a = pa[idx];
          op_b = pb[idx];
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", got, 3);
    check("b2b_accepts", acc_t.size(), 3);
    if (acc_t.size() == 3) begin
      check("b2b_spacing01", acc_t[1] - acc_t[0], N + 2);
      check("b2b_spacing12", acc_t[2] - acc_t[1], N + 2);
    end
    step;

`ifdef CLA_SEQ_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

    for (int r = 0; r < 16; r++) begin
      logic s;
`ifdef CLA_SEQ_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), s, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
